ram_ws: RTL
===========

RAM_WS -- requirements
Module: ram_ws

Interface
REQ-001 Parameter ADDR_WIDTH, 16, byte-address width of both ports; memory holds 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 Parameter GNT_DELAY, 0, cycles from first req to gnt, range 0..7, same for both ports.
REQ-003 Parameter RVALID_LATENCY, 1, cycles from accept (req&&gnt) to rvalid, range 1..4.
REQ-004 clk_i  input  1  single clock, all state on rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 instr_req_i  input  1  instruction read request.
REQ-007 instr_addr_i  input  ADDR_WIDTH  instruction byte address; bits [1:0] ignored.
REQ-008 instr_gnt_o  output  1  instruction request accepted.
REQ-009 instr_rvalid_o  output  1  instruction read data valid.
REQ-010 instr_rdata_o  output  32  instruction read data.
REQ-011 data_req_i  input  1  data request.
REQ-012 data_addr_i  input  ADDR_WIDTH  data byte address; bits [1:0] ignored.
REQ-013 data_we_i  input  1  1 = write, 0 = read.
REQ-014 data_be_i  input  4  byte enables, bit n = byte lane n.
REQ-015 data_wdata_i  input  32  write data.
REQ-016 data_gnt_o  output  1  data request accepted.
REQ-017 data_rvalid_o  output  1  data response valid (reads and writes).
REQ-018 data_rdata_o  output  32  data read data.

Function
REQ-019 Each port shall run an independent FSM, states IDLE and WAIT, with a 3-bit delay counter.
REQ-020 GNT_DELAY=0: gnt shall equal req combinationally in IDLE; FSM never leaves IDLE.
REQ-021 GNT_DELAY>0: req in IDLE shall move to WAIT with counter=1; gnt shall assert for exactly one cycle when counter==GNT_DELAY, then FSM returns to IDLE.
REQ-022 req deasserted while in WAIT shall return FSM to IDLE, clear counter, no gnt.
REQ-023 Each new request after a gnt shall incur the full GNT_DELAY; no back-to-back bypass when GNT_DELAY>0.
REQ-024 Read data shall be sampled from the array on the accept edge and delivered with a one-cycle rvalid exactly RVALID_LATENCY cycles later.
REQ-025 Up to RVALID_LATENCY accepted transactions per port may be in flight; responses in accept order.
REQ-026 Data write shall update only lanes with data_be_i set, on the accept edge; its response shall carry rdata=0.
REQ-027 rdata outputs shall be 0 in every cycle rvalid is low.
REQ-028 Instruction read and data write to the same word accepted in the same cycle: instruction read returns pre-write contents.
REQ-029 Data write followed by any read of that word accepted in a later cycle shall return the written value.
REQ-030 No gnt shall assert without a req in the same cycle.

Reset
REQ-031 rstn_i low shall immediately force gnt, rvalid, rdata outputs to 0, FSMs to IDLE, counters to 0, response pipelines empty.
REQ-032 Transactions accepted before reset shall never produce rvalid after reset release.
REQ-033 Memory array contents shall not be reset.

Structure
REQ-034 Package ram_ws_pkg shall hold the FSM state enum, MAX_GNT_DELAY=7 and MAX_RVALID_LATENCY=4.
REQ-035 Sub-module ram_ws_port (FSM, counter, rvalid/rdata shift pipeline) shall be instantiated once per port; the word array lives in ram_ws.
REQ-036 Out-of-range parameters shall stop elaboration with an error.

Verification
REQ-037 GNT_DELAY=0, RVALID_LATENCY=1, instr_req held, addr 0x80,0x84,... -> gnt every cycle, rvalid each next cycle, data in order.
REQ-038 GNT_DELAY=3: data_req rises cycle 0 -> data_gnt_o high only cycle 3; req dropped in cycle 2 -> no gnt, FSM IDLE.
REQ-039 Write 0xDEADBEEF be=4'b0101 to word 0x100 holding 0 -> later read returns 0x00AD00EF.
REQ-040 Same cycle: data write 0x12345678 to 0x200 (was 0xAAAAAAAA) and instr read 0x200 -> instr_rdata_o 0xAAAAAAAA; next instr read 0x12345678.
REQ-041 RVALID_LATENCY=4, four back-to-back reads, rstn_i low after third accept -> outputs 0 at once, no rvalid after release.

Source files
------------

// File: rtl/ram_ws_pkg.sv
// ram_ws_pkg: shared definitions for the wait-state RAM model.
//   port_state_e       - per-port grant FSM states (IDLE, WAIT)
//   MAX_GNT_DELAY      - largest supported request-to-grant delay
//   MAX_RVALID_LATENCY - largest supported accept-to-rvalid latency
//   merge_bytes()      - byte-lane merge used for masked writes
package ram_ws_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } port_state_e;

  localparam int MAX_GNT_DELAY      = 7;
  localparam int MAX_RVALID_LATENCY = 4;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_ws_port.sv
// ram_ws_port: grant FSM plus response pipeline for one RAM port.
// Ports:
//   clk, rstn    - clock, asynchronous active-low reset
//   req          - request from the master
//   sample_data  - word to return if the request is accepted this cycle
//                  (already forced to 0 by the parent for writes)
//   gnt          - request accepted (combinational, gated by reset)
//   rvalid       - response valid, RVALID_LATENCY cycles after accept
//   rdata        - response data, 0 whenever rvalid is low
module ram_ws_port
  import ram_ws_pkg::*;
#(
  parameter int GNT_DELAY      = 0,
  parameter int RVALID_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic [31:0] sample_data,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata
);

  port_state_e state_r, state_next_s;
  logic [2:0]  cnt_r, cnt_next_s;
  logic        gnt_s;
  logic        accept_s;

  // Response pipeline: slot 0 is loaded on accept, the last slot drives outputs.
  logic [RVALID_LATENCY-1:0] vld_r;
  logic [31:0]               dat_r [RVALID_LATENCY];

  // State and delay counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state and grant decode; a zero delay grants straight from IDLE.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    gnt_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          if (GNT_DELAY == 0) begin
            gnt_s = 1'b1;
          end else begin
            state_next_s = WAIT;
            cnt_next_s   = 3'd1;
          end
        end else begin
          cnt_next_s = 3'd0;
        end
      end
      WAIT: begin
        if (!req) begin
          // Abandoned request: forget the partial wait.
          state_next_s = IDLE;
          cnt_next_s   = 3'd0;
        end else if (cnt_r == 3'(GNT_DELAY)) begin
          // Back to IDLE so the next request pays the full delay again.
          gnt_s        = 1'b1;
          state_next_s = IDLE;
          cnt_next_s   = 3'd0;
        end else begin
          cnt_next_s = cnt_r + 3'd1;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 3'd0;
      end
    endcase
  end

  // Grant must drop the instant reset asserts, even with a zero delay.
  assign gnt      = gnt_s & rstn;
  assign accept_s = req & gnt;

  // Response shift pipeline; data is zeroed in empty slots so rdata idles at 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_r <= '0;
      for (int i = 0; i < RVALID_LATENCY; i++) begin
        dat_r[i] <= 32'h0;
      end
    end else begin
      vld_r[0] <= accept_s;
      dat_r[0] <= accept_s ? sample_data : 32'h0;
      for (int i = 1; i < RVALID_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign rvalid = vld_r[RVALID_LATENCY-1];
  assign rdata  = dat_r[RVALID_LATENCY-1];

endmodule

// File: rtl/ram_ws.sv
// ram_ws: dual-port (instruction read / data read-write) word RAM with
// configurable grant delay and read latency.
// Ports:
//   clk_i, rstn_i                 - clock, asynchronous active-low reset
//   instr_req_i, instr_addr_i     - instruction read request, byte address
//   instr_gnt_o, instr_rvalid_o,
//   instr_rdata_o                 - instruction grant and response
//   data_req_i, data_addr_i,
//   data_we_i, data_be_i,
//   data_wdata_i                  - data request, byte address, write controls
//   data_gnt_o, data_rvalid_o,
//   data_rdata_o                  - data grant and response (writes return 0)
module ram_ws
  import ram_ws_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int GNT_DELAY      = 0,
  parameter int RVALID_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o
);

  localparam int WORD_AW = ADDR_WIDTH - 2;
  localparam int WORDS   = 1 << WORD_AW;

  if (GNT_DELAY < 0 || GNT_DELAY > MAX_GNT_DELAY) begin : g_bad_gnt_delay
    $error("ram_ws: GNT_DELAY=%0d outside 0..%0d", GNT_DELAY, MAX_GNT_DELAY);
  end
  if (RVALID_LATENCY < 1 || RVALID_LATENCY > MAX_RVALID_LATENCY) begin : g_bad_latency
    $error("ram_ws: RVALID_LATENCY=%0d outside 1..%0d", RVALID_LATENCY, MAX_RVALID_LATENCY);
  end
  if (ADDR_WIDTH < 3 || ADDR_WIDTH > 32) begin : g_bad_addr_width
    $error("ram_ws: ADDR_WIDTH=%0d outside 3..32", ADDR_WIDTH);
  end

  logic [31:0]        mem_r [WORDS];
  logic [WORD_AW-1:0] instr_word_s;
  logic [WORD_AW-1:0] data_word_s;
  logic [31:0]        instr_sample_s;
  logic [31:0]        data_sample_s;
  logic               data_write_s;
  logic               unused_addr_bits_s;

  // Byte offsets are don't-care; all accesses are whole words.
  assign instr_word_s       = instr_addr_i[ADDR_WIDTH-1:2];
  assign data_word_s        = data_addr_i[ADDR_WIDTH-1:2];
  assign unused_addr_bits_s = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  // Reads see the array before this edge's write, so a same-cycle
  // instruction read of a word being written returns the old contents.
  assign instr_sample_s = mem_r[instr_word_s];
  assign data_sample_s  = data_we_i ? 32'h0 : mem_r[data_word_s];
  assign data_write_s   = data_req_i & data_gnt_o & data_we_i;

  // Word array, deliberately not reset; masked write on data accept.
  always_ff @(posedge clk_i) begin
    if (data_write_s) begin
      mem_r[data_word_s] <= merge_bytes(mem_r[data_word_s], data_wdata_i, data_be_i);
    end
  end

  ram_ws_port #(
    .GNT_DELAY      (GNT_DELAY),
    .RVALID_LATENCY (RVALID_LATENCY)
  ) u_instr_port (
    .clk         (clk_i),
    .rstn        (rstn_i),
    .req         (instr_req_i),
    .sample_data (instr_sample_s),
    .gnt         (instr_gnt_o),
    .rvalid      (instr_rvalid_o),
    .rdata       (instr_rdata_o)
  );

  ram_ws_port #(
    .GNT_DELAY      (GNT_DELAY),
    .RVALID_LATENCY (RVALID_LATENCY)
  ) u_data_port (
    .clk         (clk_i),
    .rstn        (rstn_i),
    .req         (data_req_i),
    .sample_data (data_sample_s),
    .gnt         (data_gnt_o),
    .rvalid      (data_rvalid_o),
    .rdata       (data_rdata_o)
  );

endmodule
